instr_dcd_burst: RTL

//  Parametrised SPI-to-register-file instruction decoder; next generation of the single-byte decoder.

---
 rtl/instr_dcd_burst.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/instr_dcd_burst.sv
`timescale 1ns/1ps
// SPI byte stream to register-file decoder: instruction byte, then multi-byte words, optional address-increment burst.
// Latency: read strobe 1 clk after instruction byte, data_out 2 clk after it, write strobe 1 clk after last data byte.
// Backpressure: none; the SPI slave guarantees >= 4 clk between byte_sync pulses and cs_n high aborts any frame.
module instr_dcd_burst #(
  parameter int ADDR_W     = 6,
  parameter int DATA_BYTES = 1,
  parameter int BURST_EN   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cs_n,
  input  logic                    byte_sync,
  input  logic [7:0]              data_in,
  output logic [7:0]              data_out,
  output logic                    read,
  output logic                    write,
  output logic [ADDR_W-1:0]       addr,
  input  logic [8*DATA_BYTES-1:0] data_read,
  output logic [8*DATA_BYTES-1:0] data_write
);

  localparam int            KW     = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int            WW     = 8 * DATA_BYTES;
  localparam logic [KW-1:0] K_LAST = KW'(DATA_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_COLLECT,
    RD_REQ,
    RD_CAP,
    RD_SHIFT,
    DRAIN
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [KW-1:0] k;
  logic [KW-1:0] k_nxt;
  logic          burst;
  logic [WW-1:0] wbuf;
  logic [WW-1:0] wword;
  logic [WW-1:0] shift;
  logic          byte_ok;
  logic          last_byte;

  // A byte only counts while the frame is open; cs_n high drops a coincident byte.
  assign byte_ok   = byte_sync & ~cs_n;
  assign last_byte = (k == K_LAST);

  // Word being assembled: previously collected bytes with the incoming byte dropped into slot k.
  always_comb begin
    wword = wbuf;
    wword[8*k +: 8] = data_in;
  end

  // MISO byte: current slot of the captured read word, zero whenever no read word is being shifted.
  always_comb begin
    data_out = 8'h00;
    if (state == RD_CAP || state == RD_SHIFT) begin
      data_out = shift[8*k +: 8];
    end
  end

  // State and byte-index register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
    end
  end

  // Next state and byte index; cs_n high overrides everything and closes the frame.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    if (cs_n) begin
      state_nxt = IDLE;
      k_nxt     = '0;
    end else begin
      case (state)
        IDLE: begin
          if (byte_sync) begin
            state_nxt = data_in[7] ? WR_COLLECT : RD_REQ;
            k_nxt     = '0;
          end
        end
        WR_COLLECT: begin
          if (byte_sync) begin
            if (last_byte) begin
              k_nxt     = '0;
              state_nxt = burst ? WR_COLLECT : DRAIN;
            end else begin
              k_nxt = k + 1'b1;
            end
          end
        end
        RD_REQ: state_nxt = RD_CAP;
        RD_CAP: begin
          k_nxt     = '0;
          state_nxt = RD_SHIFT;
        end
        RD_SHIFT: begin
          if (byte_sync) begin
            if (last_byte) begin
              k_nxt     = '0;
              state_nxt = burst ? RD_REQ : DRAIN;
            end else begin
              k_nxt = k + 1'b1;
            end
          end
        end
        DRAIN:   state_nxt = DRAIN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath: instruction latch, word assembly, registered strobes, read capture, address stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= '0;
      burst      <= 1'b0;
      wbuf       <= '0;
      shift      <= '0;
      data_write <= '0;
      write      <= 1'b0;
      read       <= 1'b0;
    end else begin
      write <= 1'b0;
      // read is high for exactly the cycle the FSM sits in RD_REQ
      read  <= (state_nxt == RD_REQ);
      if (byte_ok && state == IDLE) begin
        addr  <= data_in[ADDR_W-1:0];
        burst <= (BURST_EN != 0) && data_in[6];
      end
      if (byte_ok && state == WR_COLLECT) begin
        wbuf <= wword;
        if (last_byte) begin
          data_write <= wword;
          write      <= 1'b1;
        end
      end
      // Step the write address only after the strobe cycle so addr matches data_write while write=1.
      if (write && burst) begin
        addr <= addr + 1'b1;
      end
      if (byte_ok && state == RD_SHIFT && last_byte && burst) begin
        addr <= addr + 1'b1;
      end
      // data_read is valid while read=1, i.e. during RD_REQ; it appears on data_out from RD_CAP on.
      if (state == RD_REQ) begin
        shift <= data_read;
      end
    end
  end

endmodule
